// File: rtl/square22_pkg.sv
// Shared types and default sizing for the square22 serial squarer sequencer.
package square22_pkg;

  localparam int unsigned SqN      = 22;
  localparam int unsigned SqDw     = 28;
  localparam int unsigned SqSettle = 2;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StSettle,
    StDone
  } sq22_state_t;

endpackage

// File: rtl/square22_pp_gen.sv
// Partial-product row generator: lane[i] = a[N-1-t] & a[i] while shifting, zero otherwise.
module square22_pp_gen
  import square22_pkg::*;
#(
  parameter int unsigned N  = SqN,
  parameter int unsigned TW = (SqN > 1) ? $clog2(SqN) : 1
) (
  input  logic [N-1:0]  a_i,
  input  logic [TW-1:0] t_i,
  input  logic          en_i,
  output logic [N-1:0]  lane_o
);

  logic [TW-1:0] idx;

  always_comb begin
    lane_o = '0;
    // Multiplier bits are walked MSB first.
    idx = TW'(N - 1) - t_i;
    if (en_i && a_i[idx]) begin
      lane_o = a_i;
    end
  end

endmodule

// File: rtl/square22_sequencer.sv
// Serial squarer sequencer: feeds partial-product rows, waits for settle, captures the result.
// Optional completed-operation counter enabled with `define SQ22_SEQ_PERF_EN.
module square22_sequencer
  import square22_pkg::*;
#(
  parameter int unsigned N      = SqN,
  parameter int unsigned DW     = SqDw,
  parameter int unsigned SETTLE = SqSettle
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [N-1:0]  op_data,
  output logic [N-1:0]  lane,
  input  logic [DW-1:0] dst_in,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          busy,
  output logic [15:0]   op_count
);

  localparam int unsigned TW = (N > 1) ? $clog2(N) : 1;

  sq22_state_t   state_q;
  logic [N-1:0]  a_q;
  logic [TW-1:0] t_q;
  logic [3:0]    settle_q;
  logic          res_valid_q;
  logic [DW-1:0] res_data_q;

  assign op_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      t_q         <= '0;
      settle_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (op_valid) begin
            a_q     <= op_data;
            t_q     <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          t_q <= t_q + 1'b1;
          if (t_q == TW'(N - 1)) begin
            settle_q <= '0;
            state_q  <= StSettle;
          end
        end
        StSettle: begin
          if (settle_q == 4'(SETTLE - 1)) begin
            res_data_q  <= dst_in;
            res_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        StDone: begin
          // Returning to idle first keeps a fresh accept out of the handshake cycle.
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  square22_pp_gen #(
    .N  (N),
    .TW (TW)
  ) u_pp_gen (
    .a_i    (a_q),
    .t_i    (t_q),
    .en_i   (state_q == StShift),
    .lane_o (lane)
  );

`ifdef SQ22_SEQ_PERF_EN
  logic        handshake;
  logic [15:0] op_count_q;

  assign handshake = (state_q == StDone) && res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (handshake && (op_count_q != 16'hFFFF)) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`else
  assign op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_square22_sequencer.sv
// Self-checking bench for square22_sequencer: random operands against a timeline reference model.
module tb_square22_sequencer;

  localparam int unsigned N       = 22;
  localparam int unsigned DW      = 28;
  localparam int unsigned SETTLE  = 2;
  localparam int unsigned SPACING = N + SETTLE + 2;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          op_valid  = 1'b0;
  logic          res_ready = 1'b0;
  logic [N-1:0]  op_data   = '0;
  logic [DW-1:0] dst_in    = '0;
  logic          op_ready;
  logic          res_valid;
  logic          busy;
  logic [N-1:0]  lane;
  logic [DW-1:0] res_data;
  logic [15:0]   op_count;

  int          n_vec     = 0;
  int          n_err     = 0;
  int          cyc       = 0;
  int          last_acc  = 0;
  int          prev_hold = 0;
  bit          prev_keep = 1'b0;
  logic [15:0] exp_count = '0;

  square22_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_data   (op_data),
    .lane      (lane),
    .dst_in    (dst_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_opc();
`ifdef SQ22_SEQ_PERF_EN
    return exp_count;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic apply_reset();
    rst_n     = 1'b0;
    op_valid  = 1'b0;
    res_ready = 1'b0;
    #1;
    check_eq("rst_lane", 32'(lane), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst_res_data", 32'(res_data), 32'd0);
    check_eq("rst_op_count", 32'(op_count), 32'd0);
    exp_count = '0;
    prev_keep = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(op_ready), 32'd1);
    check_eq("post_rst_busy", 32'(busy), 32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  // abort_k >= 0 resets at that SHIFT step, -2 resets in DONE.
  task automatic run_op(input logic [N-1:0] a, input int hold, input int abort_k, input bit keep);
    logic [DW-1:0] exp_res;
    logic [N-1:0]  sh;
    logic [N-1:0]  exp_lane;
    exp_res  = '0;
    op_valid = 1'b1;
    op_data  = a;
    check_eq("idle_ready", 32'(op_ready), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);
    for (int k = 0; k < int'(N); k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (keep && prev_keep) check_eq("spacing", 32'(cyc - last_acc), 32'(SPACING + prev_hold));
        last_acc = cyc;
      end
      op_valid  = keep ? 1'b1 : 1'($urandom_range(0, 1));
      op_data   = N'($urandom);
      res_ready = 1'($urandom_range(0, 1));
      dst_in    = DW'($urandom);
      if (k == abort_k) begin
        apply_reset();
        return;
      end
      sh       = a >> (int'(N) - 1 - k);
      exp_lane = sh[0] ? a : '0;
      check_eq("shift_lane", 32'(lane), 32'(exp_lane));
      check_eq("shift_busy", 32'(busy), 32'd1);
      check_eq("shift_ready", 32'(op_ready), 32'd0);
      check_eq("shift_res_valid", 32'(res_valid), 32'd0);
    end
    for (int s = 0; s < int'(SETTLE); s++) begin
      @(negedge clk);
      check_eq("settle_lane", 32'(lane), 32'd0);
      check_eq("settle_res_valid", 32'(res_valid), 32'd0);
      check_eq("settle_busy", 32'(busy), 32'd1);
      dst_in = DW'($urandom);
      if (s == int'(SETTLE) - 1) exp_res = dst_in;
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      if (abort_k == -2) begin
        apply_reset();
        return;
      end
      check_eq("done_res_valid", 32'(res_valid), 32'd1);
      check_eq("done_res_data", 32'(res_data), 32'(exp_res));
      check_eq("done_ready", 32'(op_ready), 32'd0);
      check_eq("done_lane", 32'(lane), 32'd0);
      res_ready = (h == hold);
      op_valid  = 1'b1;
      dst_in    = DW'($urandom);
    end
    @(negedge clk);
`ifdef SQ22_SEQ_PERF_EN
    if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
`endif
    check_eq("after_res_valid", 32'(res_valid), 32'd0);
    check_eq("after_busy", 32'(busy), 32'd0);
    check_eq("after_ready", 32'(op_ready), 32'd1);
    check_eq("op_count", 32'(op_count), 32'(exp_opc()));
    op_valid  = keep;
    res_ready = 1'b0;
    prev_keep = keep;
    prev_hold = hold;
  endtask

  initial begin
    rst_n = 1'b0;
    #2;
    check_eq("init_lane", 32'(lane), 32'd0);
    check_eq("init_busy", 32'(busy), 32'd0);
    check_eq("init_res_valid", 32'(res_valid), 32'd0);
    check_eq("init_res_data", 32'(res_data), 32'd0);
    check_eq("init_op_count", 32'(op_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("init_ready", 32'(op_ready), 32'd1);

    run_op(22'h000003, 0, -1, 1'b0);
    run_op(22'h3FFFFF, 2, -1, 1'b0);
    run_op(N'($urandom), 10, -1, 1'b0);
    run_op('0, 1, -1, 1'b0);

`ifdef SQ22_SEQ_PERF_EN
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    exp_count = 16'hFFFF;
    run_op(N'($urandom), 0, -1, 1'b0);
`endif

    run_op(N'($urandom), 0, 10, 1'b0);
    run_op(22'h000001, 0, -1, 1'b0);
    run_op(N'($urandom), 3, -2, 1'b0);
    run_op(N'($urandom), 0, -1, 1'b0);

    repeat (4) run_op(N'($urandom), 0, -1, 1'b1);

    for (int i = 0; i < 25; i++) begin
      run_op(N'($urandom), int'($urandom_range(0, 4)), -1, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/square22_sequencer.md
SQUARE22_SEQUENCER -- requirements
Module: square22_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 22, meaning the operand width and the number of serial lanes and shift depth.
REQ-002 The block SHALL have parameter DW, default 28, meaning the width of the captured compressor result.
REQ-003 The block SHALL have parameter SETTLE, default 2, legal range 1..15, meaning the cycles waited after the last shift before capture.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port op_valid, input, 1 bit: the operand is offered.
REQ-007 Port op_ready, output, 1 bit: the block accepts the operand this cycle.
REQ-008 Port op_data, input, N bits: the operand a.
REQ-009 Port lane, output, N bits: serial bits to the shift-register inputs src0_..src(N-1)_, one bit per lane.
REQ-010 Port dst_in, input, DW bits: compressor outputs dst0..dst(DW-1), concatenated with dst0 as the LSB.
REQ-011 Port res_valid, output, 1 bit: the result is held.
REQ-012 Port res_ready, input, 1 bit: the consumer accepts the result.
REQ-013 Port res_data, output, DW bits: the captured result.
REQ-014 Port busy, output, 1 bit: the FSM is not in IDLE.
REQ-015 Port op_count, output, 16 bits: the completed-operation counter (see Configuration).

Function
REQ-016 The FSM SHALL have the states IDLE, SHIFT, SETTLE and DONE.
REQ-017 op_ready SHALL be 1 only in IDLE; an op_valid&&op_ready cycle SHALL latch op_data into a, clear bit counter t to 0, and move to SHIFT.
REQ-018 In SHIFT, lane[i] SHALL equal a[N-1-t] & a[i] (partial-product row i, MSB first); t SHALL increment each cycle.
REQ-019 SHIFT SHALL last exactly N cycles (t = 0..N-1); at t==N-1 the FSM SHALL move to SETTLE with a settle counter of 0.
REQ-020 lane SHALL be all zeros in every state other than SHIFT.
REQ-021 SETTLE SHALL last exactly SETTLE cycles; on the last SETTLE cycle, res_data SHALL capture dst_in, res_valid SHALL be set, and the FSM SHALL move to DONE.
REQ-022 In DONE, res_valid SHALL be 1 and res_data SHALL be held stable until res_ready is sampled 1; that cycle SHALL clear res_valid and return the FSM to IDLE.
REQ-023 A new operand SHALL NOT be accepted in the same cycle as the result handshake; the minimum spacing is N+SETTLE+2 cycles.
REQ-024 Latency from op acceptance to res_valid rising SHALL be exactly N+SETTLE cycles.
REQ-025 op_valid SHALL be ignored outside IDLE; res_ready SHALL be ignored outside DONE.
REQ-026 Operand a=0 SHALL still execute the full sequence with all-zero lanes.

Reset
REQ-027 Asserting rst_n low at any time, including mid-SHIFT or in DONE, SHALL immediately force: FSM=IDLE, t=0, a=0, lane=0, res_valid=0, res_data=0, busy=0, op_count=0; op_ready SHALL be 1 after release.
REQ-028 After reset release, the first operation SHALL behave identically to the first operation after power-up.

Configuration
REQ-029 With SQ22_SEQ_PERF_EN defined, op_count SHALL increment on each result handshake and saturate at 16'hFFFF.
REQ-030 Without SQ22_SEQ_PERF_EN, op_count SHALL be tied to 0 and no counter flops SHALL be instantiated; all other behaviour SHALL be identical.

Structure
REQ-031 Package square22_pkg SHALL hold the FSM state enum (sq22_state_t) and the default constants N=22, DW=28 and SETTLE=2.
REQ-032 One sub-module, square22_pp_gen, SHALL be combinational and produce lane from a and t; the FSM and counters SHALL remain in square22_sequencer.

Verification
REQ-033 Accept op_data=22'h000003 -> lane=22'h000003 only at t=20 and t=21, zero at all other t; res_valid rises exactly 24 cycles after acceptance.
REQ-034 Accept a=22'h3FFFFF -> lane=22'h3FFFFF for all 22 SHIFT cycles; res_data equals dst_in sampled on the final SETTLE cycle.
REQ-035 Hold res_ready=0 for 10 cycles in DONE while dst_in toggles -> res_data stays constant, op_ready=0 throughout, and the extra op_valid is ignored.
REQ-036 Drop rst_n low at t=10 of SHIFT -> lane=0, busy=0, res_valid=0 immediately; a subsequent a=22'h000001 completes normally.
REQ-037 With SQ22_SEQ_PERF_EN, run 3 operations -> op_count=3; preload the counter to 16'hFFFF and run one more -> op_count stays 16'hFFFF; without the macro, op_count=0 throughout.
REQ-038 Back-to-back op_valid held high with res_ready=1 -> acceptances are spaced exactly 26 cycles apart.
